// File: rtl/channel_noise_adder.sv
// Rx channel noise adder: buffers uniform RNG words, turns each into an approximate
// Gaussian sample (sum of four 16-bit fields, scaled by sigma) and adds it to a symbol.
// Optional NOISE_STATS_EN adds a sticky 16-bit saturation counter port (sat_count).
module channel_noise_adder #(
  parameter int SYM_W       = 8,
  parameter int SIGMA_W     = 8,
  parameter int OUT_W       = 10,
  parameter int RFIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [63:0]         rand_in,
  input  logic                rand_in_valid,
  output logic                urng_en,
  input  logic [SIGMA_W-1:0]  sigma,
  input  logic [SYM_W-1:0]    sym_in,
  input  logic                sym_in_valid,
  output logic                sym_in_ready,
  output logic [OUT_W-1:0]    sym_out,
  output logic                sym_out_valid,
  input  logic                sym_out_ready,
  output logic                rand_drop
`ifdef NOISE_STATS_EN
  ,
  output logic [15:0]         sat_count
`endif
);

  localparam int PTR_W = $clog2(RFIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int G_W   = 19;
  localparam int P_W   = G_W + SIGMA_W + 1;
  localparam int N_W   = P_W - 16;
  localparam int T_W   = ((SYM_W > N_W) ? SYM_W : N_W) + 1;
  localparam int OMAX  = (2 ** (OUT_W - 1)) - 1;
  localparam int OMIN  = -(2 ** (OUT_W - 1));

  // Random-word FIFO
  logic [63:0]      fifo_mem [RFIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_full;
  logic             push;

  // Pipeline registers
  logic                    s1_valid;
  logic signed [G_W-1:0]   s1_g;
  logic signed [SYM_W-1:0] s1_sym;
  logic                    s2_valid;
  logic signed [N_W-1:0]   s2_n;
  logic signed [SYM_W-1:0] s2_sym;

  logic                    adv;
  logic                    accept;
  logic [63:0]             head;
  logic [17:0]             s_sum;
  logic signed [G_W-1:0]   g_val;
  logic signed [P_W-1:0]   p_val;
  logic signed [N_W-1:0]   n_val;
  logic signed [T_W-1:0]   t_val;
  logic signed [31:0]      t_ext;
  logic                    sat_hi;
  logic                    sat_lo;
  logic [OUT_W-1:0]        sat_val;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // a producer holding valid must not expect ready to be held, and the output side keeps
  // sym_out/sym_out_valid stable while sym_out_valid && !sym_out_ready.
  assign fifo_full    = (count == CNT_W'(RFIFO_DEPTH));
  assign push         = rand_in_valid && !fifo_full;
  assign adv          = !sym_out_valid || sym_out_ready;
  assign sym_in_ready = !rst && adv && (count != '0);
  assign accept       = sym_in_valid && sym_in_ready;
  assign head         = fifo_mem[rd_ptr];

  // S1: central-limit sum, re-centred around zero
  assign s_sum = 18'(head[15:0]) + 18'(head[31:16]) + 18'(head[47:32]) + 18'(head[63:48]);
  assign g_val = $signed({1'b0, s_sum}) - 19'sd131072;

  // S2: scale by sigma, keep the integer part with floor rounding
  assign p_val = $signed(P_W'(s1_g)) * $signed(P_W'({1'b0, sigma}));
  assign n_val = N_W'(p_val >>> 16);

  // S3: add and saturate to the output range
  assign t_val   = $signed(T_W'(s2_sym)) + $signed(T_W'(s2_n));
  assign t_ext   = 32'(t_val);
  assign sat_hi  = (t_ext > OMAX);
  assign sat_lo  = (t_ext < OMIN);
  assign sat_val = sat_hi ? OUT_W'(OMAX) : (sat_lo ? OUT_W'(OMIN) : OUT_W'(t_ext));

  always_ff @(posedge clk) begin
    if (push && !rst) fifo_mem[wr_ptr] <= rand_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      urng_en       <= 1'b0;
      rand_drop     <= 1'b0;
      s1_valid      <= 1'b0;
      s1_g          <= '0;
      s1_sym        <= '0;
      s2_valid      <= 1'b0;
      s2_n          <= '0;
      s2_sym        <= '0;
      sym_out_valid <= 1'b0;
      sym_out       <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (accept) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, accept})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // Two entries of slack cover the generator's response latency to urng_en
      urng_en   <= (count <= CNT_W'(RFIFO_DEPTH - 2));
      rand_drop <= rand_in_valid && fifo_full;

      if (adv) begin
        s1_valid <= accept;
        if (accept) begin
          s1_g   <= g_val;
          s1_sym <= $signed(sym_in);
        end
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_n   <= n_val;
          s2_sym <= s1_sym;
        end
        sym_out_valid <= s2_valid;
        if (s2_valid) sym_out <= sat_val;
      end
    end
  end

`ifdef NOISE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_count <= '0;
    end else if (adv && s2_valid && (sat_hi || sat_lo) && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_channel_noise_adder.sv
// Self-checking bench for channel_noise_adder: reference model of the rand FIFO and noise
// arithmetic feeds an expected queue; a negedge monitor compares every output transfer.
module tb_channel_noise_adder;

  localparam int SYM_W   = 8;
  localparam int SIGMA_W = 8;
  localparam int OUT_W   = 10;
  localparam int DEPTH   = 4;
  localparam int OMAX    = 511;
  localparam int OMIN    = -512;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [63:0]        rand_in = '0;
  logic               rand_in_valid = 1'b0;
  logic               urng_en;
  logic [SIGMA_W-1:0] sigma = '0;
  logic [SYM_W-1:0]   sym_in = '0;
  logic               sym_in_valid = 1'b0;
  logic               sym_in_ready;
  logic [OUT_W-1:0]   sym_out;
  logic               sym_out_valid;
  logic               sym_out_ready = 1'b0;
  logic               rand_drop;
`ifdef NOISE_STATS_EN
  logic [15:0]        sat_count;
`endif

  channel_noise_adder #(
    .SYM_W(SYM_W), .SIGMA_W(SIGMA_W), .OUT_W(OUT_W), .RFIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rand_in(rand_in),
    .rand_in_valid(rand_in_valid),
    .urng_en(urng_en),
    .sigma(sigma),
    .sym_in(sym_in),
    .sym_in_valid(sym_in_valid),
    .sym_in_ready(sym_in_ready),
    .sym_out(sym_out),
    .sym_out_valid(sym_out_valid),
    .sym_out_ready(sym_out_ready),
    .rand_drop(rand_drop)
`ifdef NOISE_STATS_EN
    ,
    .sat_count(sat_count)
`endif
  );

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int acc_count = 0;
  int last_out = 0;
  logic [63:0]      rq[$];
  logic [OUT_W-1:0] exp_q[$];
  int               acc_cyc_q[$];
  bit drop_exp = 1'b0;
  bit urng_exp = 1'b0;
  bit lat_chk = 1'b0;
  bit stalled = 1'b0;
  logic [OUT_W-1:0] stall_val = '0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // Noise model straight from the arithmetic definition
  function automatic int ref_noise(input logic [63:0] w, input int sg, input int sy);
    longint s, g, p, n, t;
    s = longint'(w[15:0]) + longint'(w[31:16]) + longint'(w[47:32]) + longint'(w[63:48]);
    g = s - 131072;
    p = g * sg;
    if (p >= 0) n = p / 65536;
    else        n = -((-p + 65535) / 65536);
    t = sy + n;
    if (t > OMAX) t = OMAX;
    if (t < OMIN) t = OMIN;
    return int'(t);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / scoreboard: checks the state left by the last edge, then predicts the next edge
  always @(negedge clk) begin
    int pre;
    int c;
    logic [OUT_W-1:0] e;
    logic [63:0] w;
    if (cyc > 0) begin
      check("urng_en", urng_en, urng_exp);
      check("rand_drop", rand_drop, drop_exp);
      if (rst) check("rst_in_ready", sym_in_ready, 0);
      else if (sym_out_ready) check("sym_in_ready", sym_in_ready, rq.size() != 0);
      if (stalled) begin
        check("hold_valid", sym_out_valid, 1);
        check("hold_data", sym_out, stall_val);
      end
      if (!rst && sym_out_valid && sym_out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_queue", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          c = acc_cyc_q.pop_front();
          check("sym_out", $signed(sym_out), $signed(e));
          if (lat_chk) check("latency", cyc - c, 3);
          else check("latency_min", (cyc - c) >= 3, 1);
          last_out = int'($signed(sym_out));
        end
      end
    end
    if (rst) begin
      rq.delete();
      exp_q.delete();
      acc_cyc_q.delete();
      drop_exp = 1'b0;
      urng_exp = 1'b0;
      stalled  = 1'b0;
    end else begin
      pre = rq.size();
      urng_exp = (pre <= DEPTH - 2);
      drop_exp = rand_in_valid && (pre == DEPTH);
      if (sym_in_valid && sym_in_ready) begin
        if (pre == 0) begin
          check("pop_empty_ready", sym_in_ready, 0);
        end else begin
          w = rq.pop_front();
          exp_q.push_back(OUT_W'(ref_noise(w, int'(sigma), int'($signed(sym_in)))));
          acc_cyc_q.push_back(cyc);
          acc_count++;
        end
      end
      if (rand_in_valid && pre < DEPTH) rq.push_back(rand_in);
      stalled   = sym_out_valid && !sym_out_ready;
      stall_val = sym_out;
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_word(input logic [63:0] w);
    rand_in = w;
    rand_in_valid = 1'b1;
    tick();
    rand_in_valid = 1'b0;
  endtask

  task automatic send_sym(input int s);
    int n0;
    n0 = acc_count;
    sym_in = SYM_W'(s);
    sym_in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (acc_count != n0) break;
    end
    if (acc_count == n0) check("accept_timeout", acc_count - n0, 1);
    sym_in_valid = 1'b0;
  endtask

  task automatic drain();
    sym_in_valid = 1'b0;
    rand_in_valid = 1'b0;
    sym_out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    logic [63:0] dw [4];
    int dsig [4];
    int dsym [4];
    int dexp [4];
    int target;
    int prev;
    dw[0] = {$urandom(), $urandom()};  dsig[0] = 0;   dsym[0] = 37;   dexp[0] = 37;
    dw[1] = 64'h8000800080008000;      dsig[1] = 255; dsym[1] = -5;   dexp[1] = -5;
    dw[2] = 64'hFFFFFFFFFFFFFFFF;      dsig[2] = 255; dsym[2] = 100;  dexp[2] = 511;
    dw[3] = 64'h0;                     dsig[3] = 128; dsym[3] = -100; dexp[3] = -356;

    repeat (3) @(posedge clk);
    #2;
    check("rst_sym_out", sym_out, 0);
    check("rst_sym_out_valid", sym_out_valid, 0);
    check("rst_urng_en", urng_en, 0);
    rst = 1'b0;

    // Directed vectors, no stalls: exact latency checked
    lat_chk = 1'b1;
    sym_out_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      sigma = SIGMA_W'(dsig[i]);
      push_word(dw[i]);
      send_sym(dsym[i]);
      drain();
      check("directed_value", last_out, dexp[i]);
    end

    // Overfill the FIFO with no symbols: words 5 and 6 are dropped
    for (int i = 0; i < 6; i++) begin
      rand_in = {$urandom(), $urandom()};
      rand_in_valid = 1'b1;
      tick();
    end
    rand_in_valid = 1'b0;
    tick();
    check("urng_low_when_full", urng_en, 0);
    sigma = SIGMA_W'($urandom_range(0, 255));
    for (int i = 0; i < 4; i++) send_sym(int'($urandom_range(0, 255)) - 128);
    drain();

    // Stream 8 symbols, then stall the output for 5 cycles
    lat_chk = 1'b0;
    target = acc_count + 8;
    sym_in = SYM_W'($urandom());
    sym_in_valid = 1'b1;
    for (int i = 0; i < 200 && acc_count < target; i++) begin
      rand_in = {$urandom(), $urandom()};
      rand_in_valid = urng_en;
      prev = acc_count;
      tick();
      if (acc_count != prev) sym_in = SYM_W'($urandom());
    end
    check("stream_accepts", acc_count, target);
    sym_in_valid = 1'b0;
    rand_in_valid = 1'b0;
    sym_out_ready = 1'b0;
    repeat (5) tick();
    check("stall_out_valid", sym_out_valid, 1);
    check("stall_in_ready", sym_in_ready, 0);
    drain();

    // Randomized phases, one with a mid-run reset
    for (int ph = 0; ph < 3; ph++) begin
      sigma = SIGMA_W'($urandom_range(0, 255));
      for (int i = 0; i < 250; i++) begin
        rst = (ph == 1 && (i == 100 || i == 101));
        sym_in = SYM_W'($urandom());
        sym_in_valid = ($urandom_range(0, 9) < 7);
        sym_out_ready = ($urandom_range(0, 3) != 0);
        rand_in = {$urandom(), $urandom()};
        rand_in_valid = urng_en ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) == 0);
        tick();
      end
      rst = 1'b0;
      drain();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached with %0d/%0d checks passed", passed, total);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/channel_noise_adder.md
Name: channel_noise_adder

Overview:
- Consumer side of the uniform RNG interface (rand word + valid, enable back to the generator) for the Rx noise simulation.
- Buffers 64-bit uniform words and converts each to an approximate Gaussian sample: central-limit sum of four 16-bit fields, scaled by sigma.
- Adds one sample per transmitted symbol and outputs the saturated noisy symbol to the Rx model over valid/ready.

Parameters:
- SYM_W, 8, signed input symbol width
- SIGMA_W, 8, unsigned noise-scale width
- OUT_W, 10, signed output width (saturating)
- RFIFO_DEPTH, 4, random-word buffer entries (power of 2, >=4)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rand_in  in  64  uniform word from the RNG
- rand_in_valid  in  1  rand_in qualifier
- urng_en  out  1  enable to the RNG
- sigma  in  SIGMA_W  noise scale; quasi-static, sampled at stage 2
- sym_in  in  SYM_W  signed symbol
- sym_in_valid  in  1  symbol valid
- sym_in_ready  out  1  symbol accepted when valid&&ready
- sym_out  out  OUT_W  signed noisy symbol
- sym_out_valid  out  1  output valid
- sym_out_ready  in  1  downstream ready
- rand_drop  out  1  one-cycle pulse: a valid rand word was dropped because the FIFO was full

Behaviour:
- Reset (sync, high): FIFO emptied; all pipeline valids cleared. Outputs are 0: urng_en, sym_in_ready, sym_out, sym_out_valid, rand_drop. rst mid-operation discards all in-flight data; no output is produced for it.
- Rand FIFO:
  - A word is pushed on rand_in_valid when count<RFIFO_DEPTH.
  - If valid arrives when full, the word is discarded and rand_drop=1 on the next cycle.
  - Pointers wrap modulo depth.
  - urng_en = registered (count <= RFIFO_DEPTH-2); the slack absorbs RNG latency.
  - Simultaneous push and pop when full is not permitted; a word arriving then is dropped.
- Pipeline advance: adv = !sym_out_valid || sym_out_ready. All stages hold when adv=0.
- sym_in_ready = adv && FIFO non-empty (registered-free, combinational from state). An accept pops one rand word in the same cycle.
- S1 (accept):
  - u0..u3 = rand[15:0], [31:16], [47:32], [63:48].
  - s = u0+u1+u2+u3, 18-bit unsigned.
  - g = s - 131072, 19-bit signed, range [-131072, 131068].
  - The symbol is registered alongside.
- S2:
  - p = g * {1'b0, sigma}, signed 28-bit.
  - n = p >>> 16: arithmetic shift, floor toward -inf, 12-bit signed.
- S3:
  - t = sign-extended sym + n.
  - Saturate to [-(2^(OUT_W-1)), 2^(OUT_W-1)-1].
  - Register into sym_out and set sym_out_valid.
- Latency: exactly 3 cycles from accept to sym_out_valid with no stall. Throughput is 1 symbol/cycle when the FIFO is non-empty and downstream is ready.
- sym_out and sym_out_valid hold stable while sym_out_valid && !sym_out_ready.
- Order is preserved. Each rand word is used for exactly one symbol, in FIFO order.

Optional Feature:
- NOISE_STATS_EN defined:
  - Adds output sat_count[15:0], reset 0.
  - Increments when an S3 result saturates and is loaded into the output register.
  - Sticks at 0xFFFF.
- Undefined: the port and counter are absent; other behaviour is identical.

Test Plan:
- sigma=0, rand=any, sym_in=37, sym_out_ready=1 -> sym_out=37, valid exactly 3 cycles after accept; FIFO count drops by 1.
- rand=0x8000800080008000, sigma=255, sym_in=-5 -> g=0, sym_out=-5.
- rand=0xFFFFFFFFFFFFFFFF, sigma=255, sym_in=100 -> g=131068, n=509, t=609, sym_out=511 (saturated; sat_count=1 when NOISE_STATS_EN).
- rand=0x0, sigma=128, sym_in=-100 -> g=-131072, n=-256, sym_out=-356.
- Stream 8 symbols, then hold sym_out_ready=0 for 5 cycles -> sym_out held constant, sym_in_ready=0, no symbol lost or duplicated; all 8 appear in order.
- No symbols, rand_in_valid=1 for 6 consecutive cycles with RFIFO_DEPTH=4 -> urng_en falls once count>=3 (registered); words 5 and 6 are dropped with rand_drop pulses; after reset, urng_en=0 for one cycle then 1.
